keypad_event: RTL and testbench
===============================

# keypad_event

Consumes the 20-bit active-low one-hot `key_data` from the keypad scanner and turns it into clean, one-per-press key events. Each event is debounced, encoded to a 5-bit key code plus decimal-digit decode, and buffered in a small FIFO. The FIFO feeds the FND/control logic over a valid/ready handshake.

## Interface
- `DEBOUNCE_CYCLES`, default 20000: number of consecutive identical samples required to accept a press or a release. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: number of event entries. Must be a power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock.
- `rstn` input 1: asynchronous active-low reset.
- `key_data` input 20: scanner output, active-low. Bit index equals key position. All ones means no key.
- `key_ready` input 1: consumer accepts the head event.
- `key_valid` output 1: head event available.
- `key_code` output 5: bit index 0–19 of the pressed key.
- `key_is_digit` output 1: the head event is a digit key.
- `key_digit` output 4: decimal value when `key_is_digit` is 1, else 0.
- `key_pressed` output 1: level, high while in HELD or RELEASE.
- `key_overflow` output 1: one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Input stage: `key_data` is registered once into `samp`. All decisions use `samp`.
- Classification of `samp`:
  - exactly one zero bit → key with code = index of that bit;
  - all ones → NONE;
  - two or more zeros → NONE (ghost or multi-key; never encoded).
- Digit map (code → digit): 2→0, 6→1, 7→2, 8→3, 11→4, 12→5, 13→6, 16→7, 17→8, 18→9. All other codes are non-digits ("/", ESC, ENT, x, -, +, F1–F4).
- FSM states: IDLE, CONFIRM, HELD, RELEASE.
  - IDLE: when `samp` is a key, latch it as the candidate, clear the counter, and go to CONFIRM.
  - CONFIRM:
    - `samp` equals the candidate → increment the counter. When the count reaches `DEBOUNCE_CYCLES` − 1, push {code, is_digit, digit} and go to HELD.
    - `samp` is a different key → restart with the new candidate.
    - `samp` is NONE → go to IDLE.
  - HELD: no further events, no auto-repeat. When `samp` is NONE, clear the counter and go to RELEASE. A different key while in HELD is ignored (no rollover).
  - RELEASE:
    - `samp` is NONE → count. When the count reaches `DEBOUNCE_CYCLES` − 1, go to IDLE.
    - `samp` is not NONE → return to HELD with no event.
- FIFO:
  - Push and pop in the same cycle are both honoured; when full, a simultaneous pop frees the slot for the push.
  - Push while full without a pop: the event is dropped and `key_overflow` pulses for 1 cycle.
  - Pop occurs when `key_valid && key_ready`. `key_ready` while empty has no effect.
  - Head outputs are registered and hold stable while `key_valid && !key_ready`.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter saturates and never wraps.

## Timing
- Reset values: FSM = IDLE, `samp` = all ones, counter = 0, FIFO empty, `key_valid` = 0, `key_code` = 0, `key_is_digit` = 0, `key_digit` = 0, `key_pressed` = 0, `key_overflow` = 0.
- Reset mid-operation discards FIFO contents and FSM state immediately. A key still held after reset release produces a new event after a fresh debounce.
- Latency: `key_data` first shows a stable pattern before edge 0. `samp` updates at edge 0. The push occurs at edge `DEBOUNCE_CYCLES`. With the FIFO empty, `key_valid` is high after edge `DEBOUNCE_CYCLES` + 1.
- `key_pressed` rises with entry to HELD, at the push edge. It falls with the RELEASE→IDLE transition.
- `key_overflow` is asserted in the cycle after the dropped push.
- Back-to-back pops are supported: one event per cycle while `key_ready` is high.

## Structure
- Shared package `keypad_pkg`: FSM state enum, `KEY_NONE` = 20'hFFFFF, key code localparams (`KC_SLASH` = 0 … `KC_F1` = 19), and a digit-decode function.
- One sub-module, `keypad_event_fifo`: a parameterised synchronous FIFO, 10 bits wide (code 5 + is_digit 1 + digit 4), with full/empty flags. The debounce FSM and encoder live in the top module.

## Test plan
- Reset: assert `rstn` = 0 with arbitrary `key_data` → all outputs 0 and `key_valid` = 0. Release reset with `key_data` = all ones → no event for 100 cycles.
- Clean press, `DEBOUNCE_CYCLES` = 4: bit 12 low (all other bits high) for 20 cycles, `key_ready` = 1 → exactly one event at edge 5: `key_code` = 12, `key_is_digit` = 1, `key_digit` = 5. `key_pressed` high until 4 cycles after release.
- Bounce: bit 7 low 2 cycles, all ones 1 cycle, bit 7 low 10 cycles → single event, `key_code` = 7, `key_digit` = 2, timed from the second low edge.
- Ghost: bits 0 and 5 low together for 20 cycles → no event, `key_pressed` = 0. Also ESC (bit 1) → `key_code` = 1, `key_is_digit` = 0, `key_digit` = 0.
- Overflow, `FIFO_DEPTH` = 4, `key_ready` = 0: five press/release cycles of keys 2, 6, 7, 8, 11 → one `key_overflow` pulse on the fifth press. Then `key_ready` = 1 → codes 2, 6, 7, 8 popped in order on consecutive cycles, then `key_valid` = 0.
- Reset mid-HELD with bit 18 still low → outputs cleared, then one new event with `key_code` = 18 after a fresh debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, key code map and the digit decoder.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONFIRM,
      ST_HELD,
      ST_RELEASE
   } kp_state_t;

   localparam logic [19:0] KEY_NONE = 20'hFFFFF;

   localparam logic [4:0] KC_SLASH = 5'd0;
   localparam logic [4:0] KC_ESC   = 5'd1;
   localparam logic [4:0] KC_0     = 5'd2;
   localparam logic [4:0] KC_MUL   = 5'd3;
   localparam logic [4:0] KC_MINUS = 5'd4;
   localparam logic [4:0] KC_PLUS  = 5'd5;
   localparam logic [4:0] KC_1     = 5'd6;
   localparam logic [4:0] KC_2     = 5'd7;
   localparam logic [4:0] KC_3     = 5'd8;
   localparam logic [4:0] KC_ENT   = 5'd9;
   localparam logic [4:0] KC_F4    = 5'd10;
   localparam logic [4:0] KC_4     = 5'd11;
   localparam logic [4:0] KC_5     = 5'd12;
   localparam logic [4:0] KC_6     = 5'd13;
   localparam logic [4:0] KC_F3    = 5'd14;
   localparam logic [4:0] KC_F2    = 5'd15;
   localparam logic [4:0] KC_7     = 5'd16;
   localparam logic [4:0] KC_8     = 5'd17;
   localparam logic [4:0] KC_9     = 5'd18;
   localparam logic [4:0] KC_F1    = 5'd19;

   localparam int EVT_W = 10;

   typedef struct packed {
      logic [4:0] code;
      logic       is_digit;
      logic [3:0] digit;
   } key_evt_t;

   function automatic key_evt_t encode_key(input logic [4:0] code);
      key_evt_t e;
      e.code     = code;
      e.is_digit = 1'b1;
      e.digit    = 4'd0;
      case (code)
         KC_0:    e.digit = 4'd0;
         KC_1:    e.digit = 4'd1;
         KC_2:    e.digit = 4'd2;
         KC_3:    e.digit = 4'd3;
         KC_4:    e.digit = 4'd4;
         KC_5:    e.digit = 4'd5;
         KC_6:    e.digit = 4'd6;
         KC_7:    e.digit = 4'd7;
         KC_8:    e.digit = 4'd8;
         KC_9:    e.digit = 4'd9;
         default: e.is_digit = 1'b0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/keypad_event_if.sv
// Valid/ready event channel from the keypad front end to the FND/control logic.
interface keypad_event_if;
   logic       key_valid;
   logic       key_ready;
   logic [4:0] key_code;
   logic       key_is_digit;
   logic [3:0] key_digit;

   modport master (output key_valid, key_code, key_is_digit, key_digit, input key_ready);
   modport slave  (input key_valid, key_code, key_is_digit, key_digit, output key_ready);
endinterface

// File: rtl/keypad_event_fifo.sv
// Small synchronous event FIFO; head reads zero while empty.
module keypad_event_fifo
   import keypad_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = EVT_W
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [AW:0]      count;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot a full-FIFO push needs.
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/keypad_event.sv
// Keypad front end: sample, debounce, encode one event per press, buffer in a FIFO.
module keypad_event
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [19:0]     key_data,
   keypad_event_if.master  evt,
   output logic            key_pressed,
   output logic            key_overflow
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   kp_state_t         state;
   logic [19:0]       samp;
   logic [4:0]        cand;
   logic [CNT_W-1:0]  cnt;
   logic              vld_p1;
   key_evt_t          evt_p1;
   key_evt_t          head;
   logic              fifo_empty, fifo_full, pop;
   logic [4:0]        zeros;
   logic [4:0]        idx;
   logic              is_key;

   // Only a single low bit is a key; ghosts and multi-key chords count as NONE.
   always_comb begin
      zeros = '0;
      idx   = '0;
      for (int i = 0; i < 20; i++) begin
         if (!samp[i]) begin
            zeros = zeros + 5'd1;
            idx   = i[4:0];
         end
      end
      is_key = (zeros == 5'd1);
   end

   assign pop = evt.key_valid && evt.key_ready;

   // Stage p0: input sample and debounce FSM; stage p1: encoded event to FIFO.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         samp         <= KEY_NONE;
         state        <= ST_IDLE;
         cand         <= '0;
         cnt          <= '0;
         vld_p1       <= 1'b0;
         evt_p1       <= '0;
         key_pressed  <= 1'b0;
         key_overflow <= 1'b0;
      end else begin
         samp         <= key_data;
         vld_p1       <= 1'b0;
         key_overflow <= vld_p1 && fifo_full && !pop;
         case (state)
            ST_IDLE: begin
               if (is_key) begin
                  cand  <= idx;
                  cnt   <= '0;
                  state <= ST_CONFIRM;
               end
            end
            ST_CONFIRM: begin
               if (!is_key) begin
                  state <= ST_IDLE;
               end else if (idx != cand) begin
                  cand <= idx;
                  cnt  <= '0;
               end else begin
                  if (cnt == CNT_LAST) begin
                     vld_p1      <= 1'b1;
                     evt_p1      <= encode_key(cand);
                     key_pressed <= 1'b1;
                     state       <= ST_HELD;
                  end
                  if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (!is_key) begin
                  cnt   <= '0;
                  state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (is_key) begin
                  state <= ST_HELD;
               end else begin
                  if (cnt == CNT_LAST) begin
                     key_pressed <= 1'b0;
                     state       <= ST_IDLE;
                  end
                  if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   keypad_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (vld_p1),
      .push_data (evt_p1),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign evt.key_valid    = !fifo_empty;
   assign evt.key_code     = head.code;
   assign evt.key_is_digit = head.is_digit;
   assign evt.key_digit    = head.digit;

endmodule

// File: tb/tb_keypad_event.sv
// Bench for keypad_event: run-length press/release model plus directed literal checks.
module tb_keypad_event;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [19:0] key_data;
   logic        key_pressed, key_overflow;

   keypad_event_if kif();

   keypad_event #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .key_data     (key_data),
      .evt          (kif.master),
      .key_pressed  (key_pressed),
      .key_overflow (key_overflow)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   task automatic check(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int classify(input logic [19:0] s);
      int n, id;
      n = 0;
      id = -1;
      for (int i = 0; i < 20; i++) if (!s[i]) begin n++; id = i; end
      return (n == 1) ? id : -1;
   endfunction

   function automatic int digit_of(input int code);
      case (code)
         2: return 0;   6: return 1;   7: return 2;   8: return 3;  11: return 4;
         12: return 5; 13: return 6;  16: return 7;  17: return 8;  18: return 9;
         default: return -1;
      endcase
   endfunction

   function automatic logic [19:0] key(input int b);
      logic [19:0] one;
      one = 20'd1;
      return ~(one << b);
   endfunction

   // Model: a key is accepted after DEB consecutive identical samples while not
   // pressed, released after DEB consecutive NONE samples; events queue up to DEPTH.
   logic [19:0] m_samp;
   int          m_prev, m_run, m_pend_code;
   bit          m_pressed, m_pend, m_ovf;
   int          m_q[$];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_samp = '1; m_prev = -1; m_run = 0;
         m_pressed = 0; m_pend = 0; m_ovf = 0;
         m_q.delete();
      end else begin
         int c;
         m_ovf = 0;
         if (m_q.size() > 0 && kif.key_ready) void'(m_q.pop_front());
         if (m_pend) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pend_code);
            else m_ovf = 1;
         end
         m_pend = 0;
         c = classify(m_samp);
         if (c == m_prev) m_run++; else m_run = 1;
         m_prev = c;
         if (!m_pressed && c >= 0 && m_run == DEB) begin
            m_pend = 1; m_pend_code = c; m_pressed = 1;
         end else if (m_pressed && c < 0 && m_run == DEB) begin
            m_pressed = 0;
         end
         m_samp = key_data;
      end
   end

   logic [9:0] popped[$];
   int         ovf_cnt = 0;

   always @(negedge clk) begin
      check("valid", kif.key_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
         check("code", kif.key_code, m_q[0]);
         check("is_digit", kif.key_is_digit, digit_of(m_q[0]) >= 0);
         check("digit", kif.key_digit, (digit_of(m_q[0]) >= 0) ? digit_of(m_q[0]) : 0);
      end
      check("pressed", key_pressed, m_pressed);
      check("overflow", key_overflow, m_ovf);
      if (rstn && kif.key_valid && kif.key_ready)
         popped.push_back({kif.key_code, kif.key_is_digit, kif.key_digit});
      if (key_overflow) ovf_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int pb, ob;
      int codes[5];
      codes = '{2, 6, 7, 8, 11};
      key_data = 20'h5A3C1;
      kif.key_ready = 1'b0;
      #1 rstn = 1'b0;
      tick(5);
      @(negedge clk);
      check("rst_valid", kif.key_valid, 0);
      check("rst_code", kif.key_code, 0);
      check("rst_is_digit", kif.key_is_digit, 0);
      check("rst_digit", kif.key_digit, 0);
      check("rst_pressed", key_pressed, 0);
      check("rst_overflow", key_overflow, 0);
      key_data = '1;
      tick(1);
      rstn = 1'b1;
      tick(100);
      check("idle_events", popped.size(), 0);

      // Clean press of key 12 (digit 5).
      kif.key_ready = 1'b1;
      pb = popped.size();
      key_data = key(12);
      tick(5);
      @(negedge clk);
      check("press_pressed_at_push", key_pressed, 1);
      check("press_valid_before", kif.key_valid, 0);
      tick(1);
      @(negedge clk);
      check("press_valid", kif.key_valid, 1);
      check("press_code", kif.key_code, 12);
      check("press_is_digit", kif.key_is_digit, 1);
      check("press_digit", kif.key_digit, 5);
      tick(13);
      key_data = '1;
      tick(4);
      check("release_pressed_hold", key_pressed, 1);
      tick(1);
      check("release_pressed_fall", key_pressed, 0);
      tick(15);
      check("press_count", popped.size() - pb, 1);

      // Bounce on key 7.
      pb = popped.size();
      key_data = key(7); tick(2);
      key_data = '1;     tick(1);
      key_data = key(7); tick(10);
      key_data = '1;     tick(20);
      check("bounce_count", popped.size() - pb, 1);
      check("bounce_event", popped[pb], {5'd7, 1'b1, 4'd2});

      // Ghost (bits 0 and 5), then ESC.
      pb = popped.size();
      key_data = ~20'h00021; tick(20);
      check("ghost_pressed", key_pressed, 0);
      key_data = '1; tick(10);
      check("ghost_count", popped.size() - pb, 0);
      key_data = key(1); tick(10);
      key_data = '1;     tick(20);
      check("esc_count", popped.size() - pb, 1);
      check("esc_event", popped[pb], {5'd1, 1'b0, 4'd0});

      // Overflow: five presses with the consumer stalled.
      kif.key_ready = 1'b0;
      ob = ovf_cnt;
      pb = popped.size();
      for (int k = 0; k < 5; k++) begin
         key_data = key(codes[k]); tick(10);
         key_data = '1;            tick(10);
      end
      check("ovf_pulses", ovf_cnt - ob, 1);
      kif.key_ready = 1'b1;
      tick(6);
      check("drain_count", popped.size() - pb, 4);
      for (int k = 0; k < 4; k++) check("drain_code", popped[pb + k][9:5], codes[k]);
      check("drain_valid", kif.key_valid, 0);

      // Reset while key 18 is held.
      kif.key_ready = 1'b0;
      key_data = key(18); tick(10);
      check("held_pressed", key_pressed, 1);
      rstn = 1'b0; tick(3);
      check("midrst_valid", kif.key_valid, 0);
      check("midrst_pressed", key_pressed, 0);
      pb = popped.size();
      rstn = 1'b1; tick(10);
      kif.key_ready = 1'b1; tick(3);
      check("rerun_count", popped.size() - pb, 1);
      check("rerun_event", popped[pb], {5'd18, 1'b1, 4'd9});
      key_data = '1; tick(20);
      check("final_valid", kif.key_valid, 0);
      check("final_pressed", key_pressed, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
